// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers that size the Wallace reduction tree.
package wallace_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned PROD_WIDTH    = 2 * WIDTH_DEFAULT;

  localparam int MAX_LEVELS = 16;
  localparam int MAX_COLS   = 128;

  // Bit count per column at every reduction level, indexed [level][column].
  typedef logic [MAX_LEVELS:0][MAX_COLS-1:0][7:0] height_tab_t;

  function automatic int fa_cells(input int h);
    return h / 3;
  endfunction

  function automatic int ha_cells(input int h);
    return (h % 3 == 2) ? 1 : 0;
  endfunction

  function automatic int pass_bits(input int h);
    return (h % 3 == 1) ? 1 : 0;
  endfunction

  // Each level: groups of three go to a full adder, a leftover pair to a half adder,
  // a single leftover passes through; carries land one column up.
  function automatic height_tab_t build_heights(input int w);
    height_tab_t t;
    int          h;
    int          n;
    t = '0;
    for (int k = 0; k < 2 * w; k++) begin
      t[0][k] = 8'((k < w) ? k + 1 : 2 * w - 1 - k);
    end
    for (int l = 1; l <= MAX_LEVELS; l++) begin
      for (int k = 0; k < 2 * w; k++) begin
        h = int'(t[l-1][k]);
        n = fa_cells(h) + ha_cells(h) + pass_bits(h);
        if (k > 0) begin
          h = int'(t[l-1][k-1]);
          n = n + fa_cells(h) + ha_cells(h);
        end
        t[l][k] = 8'(n);
      end
    end
    return t;
  endfunction

  // First level at which no column holds more than two bits.
  function automatic int tree_levels(input height_tab_t t, input int w);
    int hmax;
    for (int l = 0; l <= MAX_LEVELS; l++) begin
      hmax = 0;
      for (int k = 0; k < 2 * w; k++) begin
        if (int'(t[l][k]) > hmax) hmax = int'(t[l][k]);
      end
      if (hmax <= 2) return l;
    end
    return MAX_LEVELS;
  endfunction

  // Number of carries entering column k of level l from column k-1 of level l-1.
  function automatic int carries_in(input height_tab_t t, input int l, input int k);
    int h;
    if (l == 0 || k == 0) return 0;
    h = int'(t[l-1][k-1]);
    return fa_cells(h) + ha_cells(h);
  endfunction

endpackage

// File: rtl/wallace_fa.sv
// Single-bit full adder; used as a half adder by tying cin low.
module wallace_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/wallace.sv
// Two-stage unsigned multiplier: structural Wallace tree, registered sum/carry, then a CPA.
module wallace
  import wallace_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c,
  output logic               out_valid
);

  localparam int W    = int'(WIDTH);
  localparam int PW   = 2 * W;
  localparam int MaxH = W;

  localparam height_tab_t HTab   = build_heights(W);
  localparam int          Levels = tree_levels(HTab, W);

  logic [PW-1:0] tree_sum;
  logic [PW-1:0] tree_car;
  logic [PW-1:0] sum_q;
  logic [PW-1:0] car_q;
  logic          vld_q;

  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    for (genvar k = 0; k < PW; k++) begin : g_col
      localparam int H   = int'(HTab[l][k]);
      localparam int NFa = fa_cells(H);
      localparam int NHa = ha_cells(H);

      logic [MaxH-1:0] bits;
      logic [MaxH-1:0] sums;
      logic [MaxH-1:0] cars;
      logic            unused_col;

      if (l == 0) begin : g_pp
        localparam int Lo = (k < W) ? 0 : k - W + 1;
        for (genvar t = 0; t < H; t++) begin : g_bit
          assign bits[t] = a[k - Lo - t] & b[Lo + t];
        end
      end else begin : g_merge
        // Own sums first, then the pass-through bit, then carries from the column below.
        localparam int HP   = int'(HTab[l-1][k]);
        localparam int Own  = fa_cells(HP) + ha_cells(HP);
        localparam int Pass = pass_bits(HP);
        localparam int NCin = carries_in(HTab, l, k);
        for (genvar t = 0; t < Own; t++) begin : g_own
          assign bits[t] = g_lvl[l-1].g_col[k].sums[t];
        end
        if (Pass == 1) begin : g_pass
          assign bits[Own] = g_lvl[l-1].g_col[k].bits[HP-1];
        end
        if (k > 0) begin : g_cin
          for (genvar t = 0; t < NCin; t++) begin : g_bit
            assign bits[Own + Pass + t] = g_lvl[l-1].g_col[k-1].cars[t];
          end
        end
      end

      if (H < MaxH) begin : g_fill
        assign bits[MaxH-1:H] = '0;
      end

      if (l < Levels) begin : g_red
        for (genvar g = 0; g < NFa; g++) begin : g_fa
          wallace_fa u_fa (
            .x   (bits[3*g]),
            .y   (bits[3*g+1]),
            .cin (bits[3*g+2]),
            .s   (sums[g]),
            .cout(cars[g])
          );
        end
        if (NHa == 1) begin : g_ha
          wallace_fa u_ha (
            .x   (bits[3*NFa]),
            .y   (bits[3*NFa+1]),
            .cin (1'b0),
            .s   (sums[NFa]),
            .cout(cars[NFa])
          );
        end
        if (NFa + NHa < MaxH) begin : g_zero
          assign sums[MaxH-1:NFa+NHa] = '0;
          assign cars[MaxH-1:NFa+NHa] = '0;
        end
      end else begin : g_out
        assign sums        = '0;
        assign cars        = '0;
        assign tree_sum[k] = bits[0];
        assign tree_car[k] = bits[1];
      end

      // Carries out of the top column are always zero because the product fits in PW bits.
      assign unused_col = ^{bits, sums, cars};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      car_q     <= '0;
      vld_q     <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      sum_q     <= tree_sum;
      car_q     <= tree_car;
      vld_q     <= in_valid;
      out_valid <= vld_q;
      if (vld_q) begin
        c <= sum_q + car_q;
      end
    end
  end

endmodule

// File: tb/tb_wallace.sv
// Randomised scoreboard bench for the two-stage Wallace multiplier.
module tb_wallace;

  localparam int W = 32;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   a        = '0;
  logic [W-1:0]   b        = '0;
  logic [2*W-1:0] c;
  logic           out_valid;

  int          total  = 0;
  int          bad    = 0;
  int          cyc    = 0;
  exp_t        sb[$];
  logic [63:0] last_c = '0;

  wallace #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit multiply; result due two edges after the driving edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    e.prod   = {32'b0, x} * {32'b0, y};
    e.due    = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
    end
  endtask

  // Monitor: pops the scoreboard on every out_valid, otherwise c must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_c", c, 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        last_c = '0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("product", c, e.prod);
          check("latency", 64'(cyc), 64'(e.due));
          last_c = e.prod;
        end
      end else begin
        check("hold_c", c, last_c);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] corner [8];
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  sel;
    corner = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
               32'h2, 32'hFFFF_FF3A, 32'hFF3A_FFFF, 32'hABCD_EF3A};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_c", c, 64'd0);
    check("por_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;

    issue(19, 15);
    idle(3);
    issue(9943000, 3302367);
    idle(2);
    issue(25983, 641987);
    idle(2);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);
    issue(32'h8000_0000, 2);
    idle(2);
    issue(0, 32'hFFFF_FFFF);
    idle(2);
    issue(32'h1234_5678, 0);
    idle(2);

    // Six back-to-back pairs must come out on six consecutive cycles.
    issue(19, 15);
    issue(9943000, 3302367);
    issue(25983, 641987);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 2);
    issue(0, 32'hFFFF_FFFF);
    idle(4);

    issue(32'hFFFF_FF3A, 32'hFF3A_FFFF);
    issue(32'hABCD_EF3A, 32'hABCA_FFFF);
    idle(4);

    // Reset lands while a product is still in flight; it must never surface.
    issue(32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_c", c, 64'd0);
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(4);
    issue(123456789, 987654321);
    idle(3);

    for (int n = 0; n < 10000;) begin
      if ($urandom_range(3) != 0) begin
        x = $urandom;
        y = $urandom;
        if ($urandom_range(7) == 0) begin
          sel = 3'($urandom_range(7));
          x   = corner[sel];
        end
        if ($urandom_range(7) == 0) begin
          sel = 3'($urandom_range(7));
          y   = corner[sel];
        end
        issue(x, y);
        n++;
      end else begin
        idle(1);
      end
    end
    idle(1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wallace.md
WALLACE -- requirements
Module: wallace

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; product width is 2*WIDTH; only 32 is required to be supported.
REQ-002 Port: clk  input  1  single clock; every register updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  qualifies a and b in the current cycle.
REQ-005 Port: a  input  32  unsigned multiplier operand.
REQ-006 Port: b  input  32  unsigned multiplicand operand.
REQ-007 Port: c  output  64  unsigned product a*b, registered.
REQ-008 Port: out_valid  output  1  high for exactly one cycle per accepted operand pair, aligned with c.

Function
REQ-009 The block SHALL compute c = a*b as a full 64-bit unsigned product with no truncation, overflow or rounding.
REQ-010 Partial products SHALL be generated as 32 AND-gated rows, pp[i][j] = a[j] & b[i], each weighted 2^(i+j).
REQ-011 Rows SHALL be reduced with a Wallace tree of full-adder (3:2) and half-adder (2:2) cells until each column holds at most two bits.
REQ-012 The final sum and carry vectors SHALL be added by a 64-bit carry-propagate adder.
REQ-013 Stage 1 SHALL register the tree's sum and carry vectors and the valid bit; stage 2 SHALL register the CPA result into c and set out_valid.
REQ-014 Latency SHALL be fixed at 2 cycles: operands sampled at rising edge N appear on c after rising edge N+2.
REQ-015 Throughput SHALL be one operand pair per cycle, with no stalls and no back-pressure.
REQ-016 The pipeline SHALL advance every cycle regardless of in_valid.
REQ-017 c SHALL hold its last value whenever out_valid is low after a non-valid slot.
REQ-018 Boundary: a or b equal to 0 SHALL give c = 0.
REQ-019 Boundary: a = b = 0xFFFFFFFF SHALL give c = 0xFFFFFFFE00000001, with no carry lost from bit 63.
REQ-020 The arithmetic datapath SHALL contain no X-propagating constructs; every tree column SHALL be fully driven.

Reset
REQ-021 While rst_n is low, all pipeline registers, c and out_valid SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight products; no out_valid SHALL appear for operands accepted before reset.
REQ-023 After rst_n deasserts, the first valid input SHALL produce its result exactly 2 cycles later.

Structure
REQ-024 A shared package SHALL hold WIDTH_DEFAULT = 32 and PROD_WIDTH = 2*WIDTH.
REQ-025 Full-adder and half-adder cells SHALL be provided by one leaf sub-module, wallace_fa, which instantiates the half-adder case with cin tied to 0.
REQ-026 The tree SHALL be built structurally, using generate loops over columns and reduction levels; a behavioural "*" SHALL NOT be used in the datapath.
REQ-027 The final CPA MAY be behavioural "+".

Verification
REQ-028 Reset, then present a=19, b=15 with in_valid high -> after 2 cycles c=285 and out_valid=1 for one cycle.
REQ-029 a=9943000, b=3302367 -> c=32835435081000; a=25983, b=641987 -> c=16680748221.
REQ-030 a=0xFFFFFFFF, b=0xFFFFFFFF -> c=0xFFFFFFFE00000001; a=0x80000000, b=2 -> c=0x100000000; a=0, b=0xFFFFFFFF -> c=0.
REQ-031 Back-to-back operands for 6 consecutive cycles (values from REQ-028 to REQ-030) -> the six correct products appear on 6 consecutive cycles starting 2 cycles after the first.
REQ-032 Assert rst_n low one cycle after a valid input -> c=0 and out_valid=0 immediately, and no stale result after release.
REQ-033 Random test: 10000 random a/b pairs, including 0xFFFF_FF3A x 0xFF3A_FFFF and 0xABCD_EF3A x 0xABCA_FFFF -> c matches the 64-bit reference product with latency 2.
